// File: rtl/floating_point_result_buffer.sv
// floating_point_result_buffer: in-order FIFO that catches results from a
// valid-only (no backpressure) FP pipeline, presents them under ready/valid,
// and hands credits back to the issuer so a compliant issuer cannot overflow it.
module floating_point_result_buffer #(
  parameter  int EXP_WIDTH    = 0,
  parameter  int FRAC_WIDTH   = 0,
  parameter  int DEPTH        = 8,
  localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [FP_WIDTH_REG-1:0] fp_i,
  input  logic                    valid_i,
  output logic [FP_WIDTH_REG-1:0] fp_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [CNT_WIDTH-1:0]    count_o,
  output logic                    error_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [FP_WIDTH_REG-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]    occ_q, occ_d;
  logic [CNT_WIDTH-1:0]    reserved_q, reserved_d;
  logic                    error_q, error_d;
  logic                    full, pop, push, issue_acc;

  // Handshake decode and outputs. Credit availability looks only at
  // registered state, so a same-cycle pop does not widen the issue window.
  always_comb begin
    full          = (occ_q == DEPTH_C);
    valid_o       = (occ_q != '0);
    pop           = valid_o && ready_i;
    push          = valid_i && (!full || pop);
    issue_ready_o = !rst_i && (reserved_q < DEPTH_C);
    issue_acc     = issue_valid_i && issue_ready_o;
    fp_o          = mem_q[rd_ptr_q];
    count_o       = occ_q;
    error_o       = error_q;
  end

  // Next-state for pointers, occupancy, credits and the sticky error flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    reserved_d = reserved_q;
    error_d    = error_q;

    // DEPTH is a power of two, so pointers wrap on their own.
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      occ_d = occ_q + CNT_WIDTH'(1);
    else if (!push && pop) occ_d = occ_q - CNT_WIDTH'(1);

    // Credits cover both in-flight and stored results; a pop without an
    // outstanding credit saturates at zero rather than wrapping.
    if (issue_acc && !pop)
      reserved_d = reserved_q + CNT_WIDTH'(1);
    else if (!issue_acc && pop && reserved_q != '0)
      reserved_d = reserved_q - CNT_WIDTH'(1);

    // Dropped word, issue without credit, or a result nobody asked for.
    if ((valid_i && full && !pop) ||
        (issue_valid_i && !issue_ready_o) ||
        (valid_i && reserved_q == '0))
      error_d = 1'b1;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      reserved_q <= '0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      reserved_q <= reserved_d;
      error_q    <= error_d;
    end
  end

  // Storage array; contents are not reset, occupancy decides what is live.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= fp_i;
  end

endmodule

// File: tb/tb_floating_point_result_buffer.sv
// Directed bench for floating_point_result_buffer (DEPTH=8, 8/23 format).
module tb_floating_point_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [31:0] fp_i;
  logic        valid_i;
  logic [31:0] fp_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  count_o;
  logic        error_o;

  int n_checks = 0;
  int n_fail   = 0;
  int acc;

  floating_point_result_buffer #(
    .EXP_WIDTH(8), .FRAC_WIDTH(23), .DEPTH(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .fp_i(fp_i), .valid_i(valid_i),
    .fp_o(fp_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        iv;
    logic        v;
    logic [31:0] fp;
    logic        rdy;
    logic        e_valid;
    logic        e_fpchk;
    logic [31:0] e_fp;
    logic [3:0]  e_cnt;
    logic        e_ir;
    logic        e_err;
  } vec_t;

  vec_t tbl[9];
  logic [31:0] vals[8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; issue_valid_i = 1'b0; fp_i = '0; valid_i = 1'b0; ready_i = 1'b0;

    // Single op: issue at cycle 0, result at cycle 7, popped at cycle 8.
    tbl[0] = '{1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 1, 0};
    for (int i = 1; i < 7; i++)
      tbl[i] = '{0, 0, 32'h0,      0, 0, 0, 32'h0,        0, 1, 0};
    tbl[7] = '{0, 1, 32'h3F800000, 1, 1, 1, 32'h3F800000, 1, 1, 0};
    tbl[8] = '{0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 1, 0};

    // Reset held for two cycles.
    tick();
    chk("rst_ready_during", {31'b0, issue_ready_o}, 32'd0);
    tick();
    chk("rst_ready_during2", {31'b0, issue_ready_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_count", {28'b0, count_o}, 32'd0);
    chk("rst_error", {31'b0, error_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("rst_ready_after", {31'b0, issue_ready_o}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      issue_valid_i = tbl[i].iv; valid_i = tbl[i].v; fp_i = tbl[i].fp; ready_i = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), {31'b0, valid_o}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_fpchk) chk($sformatf("tbl%0d_fp", i), fp_o, tbl[i].e_fp);
      chk($sformatf("tbl%0d_count", i), {28'b0, count_o}, {28'b0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_ready", i), {31'b0, issue_ready_o}, {31'b0, tbl[i].e_ir});
      chk($sformatf("tbl%0d_error", i), {31'b0, error_o}, {31'b0, tbl[i].e_err});
    end
    issue_valid_i = 0; valid_i = 0; ready_i = 0;
    chk("single_reserved", {28'b0, dut.reserved_q}, 32'd0);

    // Credit stall: compliant issuer, no draining.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      issue_valid_i = issue_ready_o;
      if (issue_ready_o) acc++;
      tick();
      if (acc == 8 && i == 7) chk("stall_ready_after8", {31'b0, issue_ready_o}, 32'd0);
    end
    issue_valid_i = 0;
    chk("stall_accepted", acc, 32'd8);
    chk("stall_reserved", {28'b0, dut.reserved_q}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      valid_i = 1; fp_i = vals[i];
      tick();
    end
    valid_i = 0;
    chk("stall_count8", {28'b0, count_o}, 32'd8);
    chk("stall_error", {31'b0, error_o}, 32'd0);
    ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), {31'b0, valid_o}, 32'd1);
      chk($sformatf("drain%0d_fp", i), fp_o, vals[i]);
      tick();
      if (i == 0) chk("drain_credit_back", {31'b0, issue_ready_o}, 32'd1);
    end
    ready_i = 0;
    chk("drain_count", {28'b0, count_o}, 32'd0);
    chk("drain_reserved", {28'b0, dut.reserved_q}, 32'd0);

    // Concurrent push and pop at occupancy 4, across pointer wrap.
    issue_valid_i = 1;
    repeat (4) tick();
    issue_valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1; fp_i = 32'h100 + i;
      tick();
    end
    valid_i = 0;
    chk("conc_count_start", {28'b0, count_o}, 32'd4);
    for (int i = 0; i < 10; i++) begin
      issue_valid_i = 1; valid_i = 1; fp_i = 32'h104 + i; ready_i = 1;
      chk($sformatf("conc%0d_fp", i), fp_o, 32'h100 + i);
      tick();
      chk($sformatf("conc%0d_count", i), {28'b0, count_o}, 32'd4);
    end
    issue_valid_i = 0; valid_i = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conc_tail%0d_fp", i), fp_o, 32'h10A + i);
      tick();
    end
    ready_i = 0;
    chk("conc_count_end", {28'b0, count_o}, 32'd0);
    chk("conc_reserved_end", {28'b0, dut.reserved_q}, 32'd0);
    chk("conc_error", {31'b0, error_o}, 32'd0);

    // Issue without credit.
    issue_valid_i = 1;
    repeat (8) tick();
    issue_valid_i = 0;
    chk("viol_issue_ready0", {31'b0, issue_ready_o}, 32'd0);
    issue_valid_i = 1;
    tick();
    issue_valid_i = 0;
    chk("viol_issue_reserved", {28'b0, dut.reserved_q}, 32'd8);
    chk("viol_issue_error", {31'b0, error_o}, 32'd1);
    do_reset();
    chk("viol_reset_error", {31'b0, error_o}, 32'd0);

    // Overflow: result arrives with the FIFO full and no pop.
    issue_valid_i = 1;
    repeat (8) tick();
    issue_valid_i = 0;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1; fp_i = 32'h200 + i;
      tick();
    end
    fp_i = 32'hDEAD; valid_i = 1;
    tick();
    valid_i = 0;
    chk("ovf_count", {28'b0, count_o}, 32'd8);
    chk("ovf_error", {31'b0, error_o}, 32'd1);
    chk("ovf_head", fp_o, 32'h200);
    ready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), fp_o, 32'h200 + i);
      tick();
    end
    ready_i = 0;
    chk("ovf_drained_count", {28'b0, count_o}, 32'd0);
    chk("ovf_error_sticky", {31'b0, error_o}, 32'd1);
    do_reset();

    // Mid-operation reset with 3 stored and 2 in flight.
    issue_valid_i = 1;
    repeat (5) tick();
    issue_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1; fp_i = 32'h300 + i;
      tick();
    end
    valid_i = 0;
    chk("mid_count3", {28'b0, count_o}, 32'd3);
    chk("mid_reserved5", {28'b0, dut.reserved_q}, 32'd5);
    rst_i = 1;
    tick();
    chk("mid_rst_count", {28'b0, count_o}, 32'd0);
    chk("mid_rst_valid", {31'b0, valid_o}, 32'd0);
    chk("mid_rst_reserved", {28'b0, dut.reserved_q}, 32'd0);
    rst_i = 0;
    #1;
    issue_valid_i = 1;
    tick();
    issue_valid_i = 0;
    repeat (2) tick();
    valid_i = 1; fp_i = 32'h40490FDB;
    tick();
    valid_i = 0;
    chk("fresh_valid", {31'b0, valid_o}, 32'd1);
    chk("fresh_fp", fp_o, 32'h40490FDB);
    ready_i = 1;
    tick();
    ready_i = 0;
    chk("fresh_count", {28'b0, count_o}, 32'd0);
    chk("fresh_reserved", {28'b0, dut.reserved_q}, 32'd0);
    chk("fresh_error", {31'b0, error_o}, 32'd0);

    // Stray result with no credit outstanding: flagged, still stored.
    valid_i = 1; fp_i = 32'h12345678;
    tick();
    valid_i = 0;
    chk("stray_error", {31'b0, error_o}, 32'd1);
    chk("stray_count", {28'b0, count_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/floating_point_result_buffer.md
# floating_point_result_buffer

Receiving end of the valid-only floating point pipeline protocol. Fixed-latency floating point units and their delay-matched buffers emit `fp`/`valid` with no backpressure. This block captures those results in an in-order FIFO and presents them downstream under a ready/valid handshake. It also returns credits upstream (`issue_ready_o`) so the issuer never launches more operations than the FIFO can absorb, which makes overflow impossible for a compliant issuer.

## Interface
- `EXP_WIDTH`, 0: exponent width; must be set (≥2) by the instantiator.
- `FRAC_WIDTH`, 0: fraction width; must be set (≥1) by the instantiator.
- `DEPTH`, 8: FIFO entries; power of two, ≥2. Sustained 1 result/cycle requires `DEPTH` ≥ pipeline latency + 2.
- `FP_WIDTH_REG`, 1+EXP_WIDTH+FRAC_WIDTH: local, word width.
- `CNT_WIDTH`, $clog2(DEPTH+1): local, counter width.

Ports:
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `issue_valid_i` in 1: issuer launches one operation into the upstream pipeline this cycle.
- `issue_ready_o` out 1: a credit is available; an issue is accepted only when `issue_valid_i` && `issue_ready_o`.
- `fp_i` in FP_WIDTH_REG: result word from the pipeline.
- `valid_i` in 1: `fp_i` valid; no backpressure, must be captured.
- `fp_o` out FP_WIDTH_REG: FIFO head; don't-care while `valid_o`=0.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: downstream accepts; pop on `valid_o` && `ready_i`.
- `count_o` out CNT_WIDTH: stored entries.
- `error_o` out 1: sticky protocol-violation flag.

## Operation
- Storage: `DEPTH` × FP_WIDTH_REG array; `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrap naturally at DEPTH-1 → 0. Array is not reset.
- `occ` register holds the number of stored entries. `count_o` = `occ`. `valid_o` = (`occ` != 0). `fp_o` = mem[`rd_ptr`] (first-word fall-through).
- `pop` = `valid_o` && `ready_i`.
- `push` = `valid_i` && (`occ` < DEPTH || `pop`). On push: write mem[`wr_ptr`], then increment `wr_ptr`.
- `occ` next value = `occ` + push − pop. Simultaneous push and pop leaves `occ` unchanged. Order is strictly FIFO.
- Credits: `reserved` register (CNT_WIDTH bits) counts issued-but-not-popped operations, which covers both in-flight and stored results.
  - Increments on an accepted issue.
  - Decrements on pop.
  - Accepted issue and pop in the same cycle leaves it unchanged.
- `issue_ready_o` = !`rst_i` && (`reserved` < DEPTH). It is combinational from registered state and does not depend on the same-cycle pop.
- `error_o` is set and held until reset on any of these:
  - `valid_i` arrives while `occ`==DEPTH and no pop occurs. The word is dropped; pointers and `occ` do not change.
  - `issue_valid_i` is asserted while `issue_ready_o`=0. The issue is ignored; `reserved` does not change.
  - `valid_i` arrives while `reserved`==0. The word is still pushed if space allows.
- `reserved` never exceeds DEPTH and never underflows. A pop with `reserved`==0 cannot occur for a compliant issuer; if it does, `reserved` saturates at 0.

## Timing
- Reset values, in the cycle after `rst_i` is sampled high: `valid_o`=0, `count_o`=0, `error_o`=0, pointers=0, `reserved`=0. `issue_ready_o` is 0 while `rst_i`=1 and 1 in the first cycle after release.
- Write-to-read latency is 1 cycle: `valid_i` at edge N makes `valid_o`=1 and `fp_o`=that word after edge N. The word can be popped in the cycle following N.
- A credit returned by a pop at edge N raises `issue_ready_o` after edge N.
- Reset mid-operation discards all stored words and credits immediately. Upstream pipeline valids must be cleared by the same `rst_i`; a stray result arriving later flags `error_o`.
- `ready_i` may toggle freely. With `valid_o`=0, `ready_i` has no effect.

## Test plan
- Reset (DEPTH=8, EXP 8/FRAC 23): hold `rst_i` 2 cycles → `valid_o`=0, `count_o`=0, `error_o`=0, `issue_ready_o`=0 during reset and 1 after.
- Single op: issue at cycle 0, `valid_i` with `fp_i`=0x3F800000 at cycle 7, `ready_i`=1 → `valid_o`=1 with `fp_o`=0x3F800000 at cycle 8, then `count_o`=0 and `reserved`=0 at cycle 9.
- Credit stall: `ready_i`=0, issue every cycle → exactly 8 issues accepted and `issue_ready_o`=0 from the cycle after the 8th. Results 0x3F800000…0x41000000 arrive and `count_o` reaches 8. Raising `ready_i` drains all 8 in order, and `issue_ready_o`=1 the cycle after the first pop.
- Concurrent push and pop at `count_o`=4 for 10 cycles with incrementing data → `count_o` stays 4, output sequence is in order with no gaps, pointers wrap cleanly.
- Violations: `issue_valid_i` while `issue_ready_o`=0 → `reserved` unchanged and `error_o`=1. Separately, force `valid_i` with `occ`=8 and `ready_i`=0 → word dropped, `count_o` stays 8, `error_o`=1 until reset.
- Mid-op reset with 3 stored and 2 in flight → next cycle `count_o`=0, `valid_o`=0, `reserved`=0; a fresh single op afterwards completes correctly.
